// File: rtl/seven_seg_pkg.sv
// Shared types and the hex-to-segment map for the 8-digit display scanner.
package seven_seg_pkg;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  en;
    logic [7:0]  pnt;
  } disp_buf_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low gfedcba pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seven_seg_scanner.sv
// Double-buffered 8-digit common-anode scanner; pins lag state/index by one cycle.
// No backpressure: data_load is always accepted into the pending buffer.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int CLKS_PER_DIGIT = 100000,
  parameter int BLANK_CLKS     = 1000
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic [31:0] data_in,
  input  logic [7:0]  dig_en,
  input  logic [7:0]  dig_pnt,
  input  logic        data_load,
  output logic [7:0]  segment,
  output logic [7:0]  anode,
  output logic        frame_done
);

  localparam int MAX_CLKS = (CLKS_PER_DIGIT > BLANK_CLKS) ? CLKS_PER_DIGIT : BLANK_CLKS;
  localparam int CW       = $clog2(MAX_CLKS + 1);
  localparam int BLANK_LAST_I = (BLANK_CLKS == 0) ? 0 : BLANK_CLKS - 1;
  localparam logic [CW-1:0] DRIVE_LAST = CW'(CLKS_PER_DIGIT - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_LAST_I);

  scan_state_t state, state_n;
  logic [2:0]    idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          first, first_n;
  disp_buf_t     pend, pend_n, act, act_n, load_buf;
  logic          boundary;
  logic [7:0]    segment_n, anode_n;

  assign load_buf = '{data: data_in, en: dig_en, pnt: dig_pnt};

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cnt_n     = cnt + 1'b1;
    first_n   = first;
    pend_n    = data_load ? load_buf : pend;
    act_n     = act;
    boundary  = 1'b0;
    segment_n = SEG_OFF;
    anode_n   = SEG_OFF;

    case (state)
      DRIVE: begin
        if (cnt == DRIVE_LAST) begin
          cnt_n = '0;
          if (BLANK_CLKS == 0) begin
            idx_n    = idx + 3'd1;
            boundary = (idx == 3'd7);
          end else begin
            state_n = BLANK;
          end
        end
      end
      default: begin
        if (BLANK_CLKS == 0 || cnt == BLANK_LAST) begin
          cnt_n   = '0;
          state_n = DRIVE;
          // The reset BLANK leads straight into digit 0 of the first frame.
          if (first) begin
            first_n  = 1'b0;
            boundary = 1'b1;
          end else begin
            idx_n    = idx + 3'd1;
            boundary = (idx == 3'd7);
          end
        end
      end
    endcase

    if (boundary) act_n = data_load ? load_buf : pend;

    if (state == DRIVE && act.en[idx]) begin
      anode_n   = ~(8'b1 << idx);
      segment_n = {~act.pnt[idx], hex_to_seg(act.data[{idx, 2'b00} +: 4])};
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= BLANK;
      idx        <= '0;
      cnt        <= '0;
      first      <= 1'b1;
      pend       <= '0;
      act        <= '0;
      segment    <= SEG_OFF;
      anode      <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      first      <= first_n;
      pend       <= pend_n;
      act        <= act_n;
      segment    <= segment_n;
      anode      <= anode_n;
      frame_done <= boundary;
    end
  end

endmodule
